// File: rtl/adap_sped_sched.sv
// Round-robin scheduler sharing one combinational adaptive-speed-control datapath across NUM_CH
// channels. Define ASC_CH_INIT_EN to add init_req/init_ch for clearing one channel's state.
module adap_sped_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic                   CLK,
    input  logic                   reset,
`ifdef ASC_CH_INIT_EN
    input  logic                   init_req,
    input  logic [CH_W-1:0]        init_ch,
`endif
    input  logic [NUM_CH-1:0]      req,
    input  logic [5*NUM_CH-1:0]    I_bus,
    input  logic [2*NUM_CH-1:0]    RATE_bus,
    input  logic [NUM_CH-1:0]      TDP_bus,
    input  logic [NUM_CH-1:0]      TR_bus,
    input  logic [13*NUM_CH-1:0]   Y_bus,
    output logic [NUM_CH-1:0]      ack,
    output logic [6:0]             al_out,
    output logic [CH_W-1:0]        al_ch,
    output logic                   al_valid,
    output logic                   busy,
    output logic [4:0]             dp_I,
    output logic [1:0]             dp_RATE,
    output logic                   dp_TDP,
    output logic                   dp_TR,
    output logic [12:0]            dp_Y,
    output logic [11:0]            dp_DMS,
    output logic [13:0]            dp_DML,
    output logic [9:0]             dp_AP,
    input  logic [11:0]            dp_DMSP,
    input  logic [13:0]            dp_DMLP,
    input  logic [9:0]             dp_APR,
    input  logic [6:0]             dp_AL
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StStore} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] grant_q;
    logic [CH_W-1:0] grant_c;
    logic [CH_W-1:0] cand;
    logic            grant_vld;
    int unsigned     sum;

    logic [11:0] dms_q [NUM_CH];
    logic [13:0] dml_q [NUM_CH];
    logic [9:0]  ap_q  [NUM_CH];

    logic [4:0]  i_ch    [NUM_CH];
    logic [1:0]  rate_ch [NUM_CH];
    logic        tdp_ch  [NUM_CH];
    logic        tr_ch   [NUM_CH];
    logic [12:0] y_ch    [NUM_CH];

    logic            init_hit;
    logic [CH_W-1:0] init_idx;

`ifdef ASC_CH_INIT_EN
    assign init_hit = init_req;
    assign init_idx = init_ch;
`else
    assign init_hit = 1'b0;
    assign init_idx = '0;
`endif

    for (genvar n = 0; n < NUM_CH; n++) begin : g_split
        assign i_ch[n]    = I_bus[5*n +: 5];
        assign rate_ch[n] = RATE_bus[2*n +: 2];
        assign tdp_ch[n]  = TDP_bus[n];
        assign tr_ch[n]   = TR_bus[n];
        assign y_ch[n]    = Y_bus[13*n +: 13];
    end

    // Scan from the highest offset down so the nearest requester after rr_ptr wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_c   = '0;
        cand      = '0;
        sum       = 0;
        for (int unsigned off = NUM_CH; off >= 1; off--) begin
            sum = 32'(rr_ptr_q) + off;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            cand = CH_W'(sum);
            if (req[cand]) begin
                grant_vld = 1'b1;
                grant_c   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_vld && !init_hit) state_d = StLoad;
            StLoad:  state_d = StExec;
            StExec:  state_d = StStore;
            StStore: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= CH_W'(NUM_CH - 1);
            grant_q  <= '0;
            for (int n = 0; n < int'(NUM_CH); n++) begin
                dms_q[n] <= '0;
                dml_q[n] <= '0;
                ap_q[n]  <= '0;
            end
            ack      <= '0;
            al_out   <= '0;
            al_ch    <= '0;
            al_valid <= 1'b0;
            dp_I     <= '0;
            dp_RATE  <= '0;
            dp_TDP   <= 1'b0;
            dp_TR    <= 1'b0;
            dp_Y     <= '0;
            dp_DMS   <= '0;
            dp_DML   <= '0;
            dp_AP    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    // Channel clear outranks service and leaves the rotation untouched.
                    if (init_hit) begin
                        dms_q[init_idx] <= '0;
                        dml_q[init_idx] <= '0;
                        ap_q[init_idx]  <= '0;
                    end else if (grant_vld) begin
                        rr_ptr_q <= grant_c;
                        grant_q  <= grant_c;
                        dp_I     <= i_ch[grant_c];
                        dp_RATE  <= rate_ch[grant_c];
                        dp_TDP   <= tdp_ch[grant_c];
                        dp_TR    <= tr_ch[grant_c];
                        dp_Y     <= y_ch[grant_c];
                        dp_DMS   <= dms_q[grant_c];
                        dp_DML   <= dml_q[grant_c];
                        dp_AP    <= ap_q[grant_c];
                    end
                end
                StLoad: begin
                end
                StExec: begin
                    dms_q[grant_q] <= dp_DMSP;
                    dml_q[grant_q] <= dp_DMLP;
                    ap_q[grant_q]  <= dp_APR;
                    al_out         <= dp_AL;
                    al_ch          <= grant_q;
                    ack            <= '0;
                    ack[grant_q]   <= 1'b1;
                    al_valid       <= 1'b1;
                end
                StStore: begin
                    ack      <= '0;
                    al_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adap_sped_sched.sv
// Randomised scoreboard bench for adap_sped_sched with a stub datapath and a rotation model.
module tb_adap_sped_sched;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [11:0] dmsp;
        logic [13:0] dmlp;
        logic [9:0]  apr;
        logic [6:0]  al;
    } dp_res_t;

    typedef struct {
        int          ch;
        int          cyc;
        logic [4:0]  i;
        logic [1:0]  rate;
        logic        tdp;
        logic        tr;
        logic [12:0] y;
        logic [11:0] dms;
        logic [13:0] dml;
        logic [9:0]  ap;
        logic [6:0]  al;
    } exp_t;

    logic                  CLK;
    logic                  reset;
    logic [NUM_CH-1:0]     req;
    logic [5*NUM_CH-1:0]   I_bus;
    logic [2*NUM_CH-1:0]   RATE_bus;
    logic [NUM_CH-1:0]     TDP_bus;
    logic [NUM_CH-1:0]     TR_bus;
    logic [13*NUM_CH-1:0]  Y_bus;
    logic [NUM_CH-1:0]     ack;
    logic [6:0]            al_out;
    logic [CH_W-1:0]       al_ch;
    logic                  al_valid;
    logic                  busy;
    logic [4:0]            dp_I;
    logic [1:0]            dp_RATE;
    logic                  dp_TDP;
    logic                  dp_TR;
    logic [12:0]           dp_Y;
    logic [11:0]           dp_DMS;
    logic [13:0]           dp_DML;
    logic [9:0]            dp_AP;
    logic [11:0]           dp_DMSP;
    logic [13:0]           dp_DMLP;
    logic [9:0]            dp_APR;
    logic [6:0]            dp_AL;
`ifdef ASC_CH_INIT_EN
    logic                  init_req;
    logic [CH_W-1:0]       init_ch;
`endif

    int checks = 0;
    int failures = 0;
    bit mon_en = 0;

    // Reference model state
    logic [11:0] m_dms [NUM_CH];
    logic [13:0] m_dml [NUM_CH];
    logic [9:0]  m_ap  [NUM_CH];
    int          m_rr = NUM_CH - 1;
    int          cyc = 0;
    int          gcyc = 0;
    bit          active = 0;
    exp_t        exp_q[$];

    adap_sped_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK      (CLK),
        .reset    (reset),
`ifdef ASC_CH_INIT_EN
        .init_req (init_req),
        .init_ch  (init_ch),
`endif
        .req      (req),
        .I_bus    (I_bus),
        .RATE_bus (RATE_bus),
        .TDP_bus  (TDP_bus),
        .TR_bus   (TR_bus),
        .Y_bus    (Y_bus),
        .ack      (ack),
        .al_out   (al_out),
        .al_ch    (al_ch),
        .al_valid (al_valid),
        .busy     (busy),
        .dp_I     (dp_I),
        .dp_RATE  (dp_RATE),
        .dp_TDP   (dp_TDP),
        .dp_TR    (dp_TR),
        .dp_Y     (dp_Y),
        .dp_DMS   (dp_DMS),
        .dp_DML   (dp_DML),
        .dp_AP    (dp_AP),
        .dp_DMSP  (dp_DMSP),
        .dp_DMLP  (dp_DMLP),
        .dp_APR   (dp_APR),
        .dp_AL    (dp_AL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the shared datapath: any deterministic function of its operands will do.
    function automatic dp_res_t dp_fn(input logic [4:0] i, input logic [1:0] rate,
                                      input logic tdp, input logic tr, input logic [12:0] y,
                                      input logic [11:0] dms, input logic [13:0] dml,
                                      input logic [9:0] ap);
        dp_res_t r;
        r.dmsp = dms + {7'd0, i} + 12'd1;
        r.dmlp = dml + {1'b0, y};
        r.apr  = tr ? 10'd256 : (tdp ? 10'd511 : ap + {rate, i, 3'd0});
        r.al   = (ap >= 10'd256) ? 7'd64 : ap[8:2];
        return r;
    endfunction

    dp_res_t dp_res;
    always_comb begin
        dp_res  = dp_fn(dp_I, dp_RATE, dp_TDP, dp_TR, dp_Y, dp_DMS, dp_DML, dp_AP);
        dp_DMSP = dp_res.dmsp;
        dp_DMLP = dp_res.dmlp;
        dp_APR  = dp_res.apr;
        dp_AL   = dp_res.al;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Model: one service per 4 clocks, next requester after the last grant wins.
    initial begin
        int c;
        exp_t e;
        dp_res_t r;
        forever begin
            @(posedge CLK or posedge reset);
            if (reset) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    m_dms[n] = '0;
                    m_dml[n] = '0;
                    m_ap[n]  = '0;
                end
                m_rr   = NUM_CH - 1;
                active = 0;
                exp_q.delete();
            end else begin
                cyc++;
                if (!active || (cyc - gcyc) >= 4) begin
                    active = 0;
`ifdef ASC_CH_INIT_EN
                    if (init_req) begin
                        m_dms[init_ch] = '0;
                        m_dml[init_ch] = '0;
                        m_ap[init_ch]  = '0;
                    end else
`endif
                    for (int off = 1; off <= NUM_CH; off++) begin
                        c = (m_rr + off) % NUM_CH;
                        if (((req >> c) & 1) != 0) begin
                            e.ch   = c;
                            e.cyc  = cyc;
                            e.i    = 5'(I_bus >> (5 * c));
                            e.rate = 2'(RATE_bus >> (2 * c));
                            e.tdp  = 1'(TDP_bus >> c);
                            e.tr   = 1'(TR_bus >> c);
                            e.y    = 13'(Y_bus >> (13 * c));
                            e.dms  = m_dms[c];
                            e.dml  = m_dml[c];
                            e.ap   = m_ap[c];
                            r      = dp_fn(e.i, e.rate, e.tdp, e.tr, e.y, e.dms, e.dml, e.ap);
                            e.al   = r.al;
                            m_dms[c] = r.dmsp;
                            m_dml[c] = r.dmlp;
                            m_ap[c]  = r.apr;
                            exp_q.push_back(e);
                            m_rr   = c;
                            gcyc   = cyc;
                            active = 1;
                            break;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every completion strobe against the oldest predicted service.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en && !reset) begin
                check("busy", 32'(busy), 32'(active && (cyc - gcyc) <= 2));
                if (al_valid) begin
                    if (exp_q.size() == 0) begin
                        flag("spurious_al_valid");
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_cycle", 32'(cyc), 32'(e.cyc + 2));
                        check("ack", 32'(ack), 32'(1) << e.ch);
                        check("al_ch", 32'(al_ch), 32'(e.ch));
                        check("al_out", 32'(al_out), 32'(e.al));
                        check("dp_I", 32'(dp_I), 32'(e.i));
                        check("dp_RATE", 32'(dp_RATE), 32'(e.rate));
                        check("dp_TDP", 32'(dp_TDP), 32'(e.tdp));
                        check("dp_TR", 32'(dp_TR), 32'(e.tr));
                        check("dp_Y", 32'(dp_Y), 32'(e.y));
                        check("dp_DMS", 32'(dp_DMS), 32'(e.dms));
                        check("dp_DML", 32'(dp_DML), 32'(e.dml));
                        check("dp_AP", 32'(dp_AP), 32'(e.ap));
                    end
                end else begin
                    check("ack_idle", 32'(ack), 32'd0);
                    if (exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2) begin
                        flag("missing_ack");
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic rand_bus();
        I_bus    = 20'($urandom());
        RATE_bus = 8'($urandom());
        TDP_bus  = 4'($urandom());
        TR_bus   = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : '0;
        Y_bus    = 52'({$urandom(), $urandom()});
    endtask

    // Requesters: drop on ack; fixed mode re-raises masked bits, random mode toggles freely.
    task automatic run_reqs(input logic [NUM_CH-1:0] mask, input int n_acks, input bit rnd);
        int got;
        int budget;
        logic [NUM_CH-1:0] bitm;
        got    = 0;
        budget = 0;
        req    = mask;
        while (got < n_acks && budget < 12 * n_acks + 40) begin
            @(negedge CLK);
            budget++;
            if (rnd) rand_bus();
            for (int c = 0; c < NUM_CH; c++) begin
                bitm = NUM_CH'(1) << c;
                if ((ack & bitm) != 0) begin
                    req = req & ~bitm;
                    got++;
                end else if ((req & bitm) == 0) begin
                    if (rnd ? ($urandom_range(0, 2) == 0) : ((mask & bitm) != 0)) req = req | bitm;
                end else if (rnd && $urandom_range(0, 63) == 0) begin
                    req = req & ~bitm;
                end
            end
        end
        check("acks_within_budget", 32'(got >= n_acks), 32'd1);
    endtask

    task automatic drain();
        req = '0;
        repeat (8) @(negedge CLK);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        I_bus    = '0;
        RATE_bus = '0;
        TDP_bus  = '0;
        TR_bus   = '0;
        Y_bus    = '0;
`ifdef ASC_CH_INIT_EN
        init_req = 1'b0;
        init_ch  = '0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_al_out", 32'(al_out), 32'd0);
        check("rst_al_ch", 32'(al_ch), 32'd0);
        check("rst_al_valid", 32'(al_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dp_ops", 32'({dp_I, dp_RATE, dp_TDP, dp_TR, dp_Y}), 32'd0);
        check("rst_dp_state", 32'(|{dp_DMS, dp_DML, dp_AP}), 32'd0);
        reset  = 1'b0;
        mon_en = 1;

        // Single request on ch2, zero operands
        run_reqs(4'b0100, 1, 0);
        drain();
        // All channels contend
        Y_bus    = 52'h0_1234_5678_9ABC;
        I_bus    = 20'h5A5A5;
        RATE_bus = 8'h1B;
        run_reqs(4'b1111, 5, 0);
        drain();
        // ch1 transition forces AP to 256, then ch1 and ch0 interleave
        TR_bus = 4'b0010;
        run_reqs(4'b0010, 1, 0);
        drain();
        TR_bus = '0;
        run_reqs(4'b0011, 2, 0);
        drain();

        // Reset while ch3 is in EXEC
        @(negedge CLK);
        req = 4'b1000;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        req   = '0;
        @(negedge CLK);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_al_valid", 32'(al_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        run_reqs(4'b1001, 2, 0);
        drain();

        // Request withdrawn during LOAD still completes exactly once
        @(negedge CLK);
        req = 4'b0100;
        @(negedge CLK);
        req = '0;
        repeat (8) @(negedge CLK);

`ifdef ASC_CH_INIT_EN
        TR_bus = 4'b0010;
        run_reqs(4'b0010, 1, 0);
        drain();
        TR_bus = '0;
        @(negedge CLK);
        init_req = 1'b1;
        init_ch  = 2'd1;
        req      = 4'b0001;
        @(negedge CLK);
        init_req = 1'b0;
        run_reqs(4'b0001, 1, 0);
        drain();
        run_reqs(4'b0010, 1, 0);
        drain();
`endif

        // Random traffic
        run_reqs('1, 300, 1);
        drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
